// File: rtl/wait_state_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wait_state_pkg
// Description : Region map, config field layout and FSM encoding shared by
//               the wait-state controller and the chip-select decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package wait_state_pkg;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_ACIA,
        RGN_VIA,
        RGN_IO2,
        RGN_CFG,
        RGN_EXP,
        RGN_ROM
    } rgn_t;

    // Region base addresses expressed as ADDR[15:10]
    localparam logic [5:0] BASE_RAM  = 6'h00;
    localparam logic [5:0] BASE_ACIA = 6'h20;
    localparam logic [5:0] BASE_VIA  = 6'h21;
    localparam logic [5:0] BASE_IO2  = 6'h22;
    localparam logic [5:0] BASE_CFG  = 6'h23;
    localparam logic [5:0] BASE_EXP  = 6'h24;
    localparam logic [5:0] BASE_ROM  = 6'h38;

    localparam int CFG_IO2_LSB  = 0;
    localparam int CFG_EXP_LSB  = 2;
    localparam int CFG_ROM_LSB  = 4;
    localparam int CFG_ACIA_LSB = 6;

    localparam logic [1:0] CFGREG_WAITS = 2'd1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    function automatic logic [1:0] region_waits(input rgn_t rgn, input logic [7:0] cfg);
        logic [1:0] n;
        n = 2'd0;
        case (rgn)
            RGN_ACIA: n = cfg[CFG_ACIA_LSB +: 2];
            RGN_IO2:  n = cfg[CFG_IO2_LSB +: 2];
            RGN_CFG:  n = CFGREG_WAITS;
            RGN_EXP:  n = cfg[CFG_EXP_LSB +: 2];
            RGN_ROM:  n = cfg[CFG_ROM_LSB +: 2];
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wait_region_decode.sv
`default_nettype none
// ============================================================================
// Module      : wait_region_decode
// Description : Combinational ADDR[15:10] to bus-region classifier.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_region_decode
    import wait_state_pkg::*;
(
    input  logic [5:0] i_addr_hi,
    output rgn_t       o_region
);

    // The 0xA000-0xDFFF gap falls inside the EXP range by design
    always_comb begin
        o_region = RGN_RAM;
        if (i_addr_hi < BASE_ACIA) begin
            o_region = RGN_RAM;
        end else if (i_addr_hi >= BASE_ROM) begin
            o_region = RGN_ROM;
        end else if (i_addr_hi >= BASE_EXP) begin
            o_region = RGN_EXP;
        end else if (i_addr_hi == BASE_CFG) begin
            o_region = RGN_CFG;
        end else if (i_addr_hi == BASE_IO2) begin
            o_region = RGN_IO2;
        end else if (i_addr_hi == BASE_VIA) begin
            o_region = RGN_VIA;
        end else begin
            o_region = RGN_ACIA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wait_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wait_state_ctrl
// Description : Per-region RDY wait-state generator with CPU-writable config.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_state_ctrl
    import wait_state_pkg::*;
#(
    parameter logic [7:0] CFG_RESET = 8'h90
) (
    input  logic       PHI2,
    input  logic       RST,
    input  logic [5:0] ADDR,
    input  logic       RWB,
    input  logic [7:0] DATA,
    output logic       RDY,
    output logic [7:0] CFG
);

    rgn_t       region;
    logic [1:0] sample_waits;

    state_t     state_q, state_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [7:0] cfg_q,   cfg_d;
    logic       rdy_q,   rdy_d;
    logic       cfg_wr_q, cfg_wr_d;

    wait_region_decode u_decode (
        .i_addr_hi (ADDR),
        .o_region  (region)
    );

    assign sample_waits = region_waits(region, cfg_q);

    // The edge leaving HOLD samples a new access exactly like IDLE does
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        rdy_d    = rdy_q;
        cfg_wr_d = cfg_wr_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 2'd1) begin
                    state_d  = ST_HOLD;
                    cnt_d    = 2'd0;
                    rdy_d    = 1'b1;
                    cfg_wr_d = 1'b0;
                    if (cfg_wr_q) begin
                        cfg_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                if (sample_waits != 2'd0) begin
                    state_d  = ST_WAIT;
                    cnt_d    = sample_waits;
                    rdy_d    = 1'b0;
                    cfg_wr_d = (region == RGN_CFG) && !RWB;
                end else begin
                    state_d  = ST_IDLE;
                    cnt_d    = 2'd0;
                    rdy_d    = 1'b1;
                    cfg_wr_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge PHI2 or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            cfg_q    <= CFG_RESET;
            rdy_q    <= 1'b1;
            cfg_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            rdy_q    <= rdy_d;
            cfg_wr_q <= cfg_wr_d;
        end
    end

    // Release the CPU the instant reset asserts, even mid-wait
    assign RDY = rdy_q | RST;
    assign CFG = cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_wait_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wait_state_ctrl
// Description : Directed and random checks of wait_state_ctrl against an
//               edge-timeline model of the bus access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wait_state_ctrl;

    logic       PHI2;
    logic       RST;
    logic [5:0] ADDR;
    logic       RWB;
    logic [7:0] DATA;
    logic       RDY;
    logic [7:0] CFG;

    int total;
    int bad;

    // Model: edge numbers at which things happen
    int         edge_cnt;
    int         next_sample;
    int         low_until;
    int         cap_edge;
    logic [7:0] m_cfg;

    wait_state_ctrl #(.CFG_RESET(8'h90)) dut (
        .PHI2 (PHI2),
        .RST  (RST),
        .ADDR (ADDR),
        .RWB  (RWB),
        .DATA (DATA),
        .RDY  (RDY),
        .CFG  (CFG)
    );

    initial PHI2 = 1'b0;
    always #5 PHI2 = ~PHI2;

    function automatic int model_waits(input int a, input logic [7:0] c);
        if (a < 16'h8000)      return 0;
        else if (a < 16'h8400) return int'(c[7:6]);
        else if (a < 16'h8800) return 0;
        else if (a < 16'h8C00) return int'(c[1:0]);
        else if (a < 16'h9000) return 1;
        else if (a < 16'hE000) return int'(c[3:2]);
        else                   return int'(c[5:4]);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_cnt, obs, exp);
        end
    endtask

    task automatic model_reset();
        next_sample = 0;
        low_until   = 0;
        cap_edge    = -1;
        m_cfg       = 8'h90;
    endtask

    task automatic step(input int a, input logic rw, input logic [7:0] d);
        int n;
        logic [15:0] a16;
        a16  = a[15:0];
        ADDR = a16[15:10];
        RWB  = rw;
        DATA = d;
        @(posedge PHI2);
        edge_cnt++;
        if (edge_cnt == cap_edge) m_cfg = d;
        if (edge_cnt >= next_sample) begin
            n           = model_waits(a, m_cfg);
            low_until   = edge_cnt + n;
            next_sample = edge_cnt + n + 1;
            if (n > 0 && a >= 16'h8C00 && a < 16'h9000 && !rw)
                cap_edge = edge_cnt + n;
        end
        #1;
        check("rdy", {7'd0, RDY}, {7'd0, (edge_cnt < low_until) ? 1'b0 : 1'b1});
        check("cfg", CFG, m_cfg);
    endtask

    // Assert RST away from a clock edge, check the async override, then release
    task automatic pulse_reset();
        #2;
        RST = 1'b1;
        #1;
        check("rdy_in_reset", {7'd0, RDY}, 8'd1);
        check("cfg_in_reset", CFG, 8'h90);
        @(posedge PHI2);
        @(negedge PHI2);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        int sel;
        int a;
        total    = 0;
        bad      = 0;
        edge_cnt = 0;
        RST      = 1'b1;
        ADDR     = 6'd0;
        RWB      = 1'b1;
        DATA     = 8'd0;
        model_reset();
        #1;
        check("rdy_reset", {7'd0, RDY}, 8'd1);
        check("cfg_reset", CFG, 8'h90);
        @(posedge PHI2);
        @(negedge PHI2);
        RST = 1'b0;

        // Zero-wait RAM reads on consecutive edges
        for (int i = 0; i < 4; i++) begin
            step(16'h0400, 1'b1, 8'h00);
            check("ram_rdy", {7'd0, RDY}, 8'd1);
        end

        // ROM: 1 wait; the RAM address on the next edge must be ignored
        step(16'hE000, 1'b1, 8'h00);
        check("rom_rdy_low", {7'd0, RDY}, 8'd0);
        step(16'h0400, 1'b1, 8'h00);
        check("rom_rdy_high", {7'd0, RDY}, 8'd1);
        // ACIA: 2 waits
        step(16'h8000, 1'b1, 8'h00);
        step(16'h8000, 1'b1, 8'h00);
        check("acia_rdy_low2", {7'd0, RDY}, 8'd0);
        step(16'h8000, 1'b1, 8'h00);

        // Config write 0x0C: EXP=3, ROM=0
        step(16'h8C00, 1'b0, 8'h0C);
        check("cfgwr_pending", CFG, 8'h90);
        step(16'h8C00, 1'b0, 8'h0C);
        check("cfgwr_captured", CFG, 8'h0C);
        for (int i = 0; i < 4; i++) step(16'h9000, 1'b1, 8'h00);
        step(16'hE000, 1'b1, 8'h00);
        check("rom_zero_wait", {7'd0, RDY}, 8'd1);

        // Config read must not capture
        step(16'h8C00, 1'b1, 8'hFF);
        step(16'h8C00, 1'b1, 8'hFF);
        check("cfg_read_nochg", CFG, 8'h0C);

        // CFG=0xC0 then reset during an ACIA access with cnt=2
        step(16'h8C00, 1'b0, 8'hC0);
        step(16'h8C00, 1'b0, 8'hC0);
        step(16'h8000, 1'b1, 8'h00);
        step(16'h8000, 1'b1, 8'h00);
        check("acia_mid_wait", {7'd0, RDY}, 8'd0);
        pulse_reset();
        step(16'hE000, 1'b1, 8'h00);
        check("post_reset_rom", {7'd0, RDY}, 8'd0);
        step(16'h0000, 1'b1, 8'h00);

        // Write clearing ACIA waits, followed directly by an ACIA access
        step(16'h8C00, 1'b0, 8'h30);
        step(16'h8C00, 1'b0, 8'h30);
        step(16'h8000, 1'b1, 8'h00);
        check("acia_new_cfg", {7'd0, RDY}, 8'd1);

        // Random traffic biased toward the I/O window and region edges
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       a = $urandom_range(0, 16'h7FFF);
                1, 2:    a = $urandom_range(16'h8000, 16'h8FFF);
                3:       a = $urandom_range(16'h9000, 16'hDFFF);
                4:       a = $urandom_range(16'hE000, 16'hFFFF);
                5:       a = 16'h8C00 + $urandom_range(0, 16'h3FF);
                default: a = $urandom_range(0, 16'hFFFF);
            endcase
            step(a, 1'($urandom_range(0, 1)), 8'($urandom));
            if (i == 300) pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/wait_state_ctrl.md
# wait_state_ctrl

Bus-cycle wait-state controller for the 65C02 system bus. It classifies each CPU access by address region and holds the CPU via RDY for a per-region number of PHI2 cycles, so slow parts (ROM, ACIA, expansion cards) run at full CPU clock. Per-region wait counts sit in a CPU-writable config register mapped into the 0x8C00 I/O slot. It sits beside the chip-select decoder and shares its region map.

## Interface

Parameters:
- CFG_RESET, 8'h90: config register value after reset (ACIA=2, ROM=1, IO2=0, EXP=0 waits).

Ports:
- PHI2  in  1  CPU clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- ADDR  in  6  CPU address bits [15:10]; valid at the rising edge that starts an access.
- RWB  in  1  CPU read(1)/write(0), valid with ADDR.
- DATA  in  8  CPU data bus; sampled only for config writes.
- RDY  out  1  to CPU RDY; 0 = hold the current cycle.
- CFG  out  8  current config register, for debug and readback.

## Operation

- Regions and wait source:
  - RAM: 0x0000-0x7FFF, 0 waits.
  - ACIA: 0x8000-0x83FF, CFG[7:6].
  - VIA: 0x8400-0x87FF, 0 waits.
  - IO2: 0x8800-0x8BFF, CFG[1:0].
  - CFGREG: 0x8C00-0x8FFF, 1 wait, fixed.
  - EXP: 0x9000-0xDFFF, CFG[3:2].
  - ROM: 0xE000-0xFFFF, CFG[5:4].
  - Gap 0xA000-0xDFFF is part of EXP.
- Config field = 2-bit wait count N (0-3).
- States:
  - IDLE: samples ADDR/RWB at every rising edge. If N=0, stay IDLE with RDY=1. If N>0, go to WAIT with cnt=N and RDY=0.
  - WAIT: cnt decrements each edge. When cnt reaches 0, RDY=1 and go to HOLD.
  - HOLD: the completing CPU cycle; ADDR is not sampled. Next edge returns to IDLE and samples normally.
- Config write: access to CFGREG with RWB=0. DATA is captured into CFG at the edge leaving WAIT; the CPU holds the data bus while RDY=0.
  - Reads of CFGREG and writes to other regions never change CFG.
- New CFG applies only to accesses sampled after the capture edge. The count of an in-flight access is never reloaded.

## Timing

- Reset values:
  - RDY=1 (forced combinationally during RST).
  - CFG=CFG_RESET.
  - State IDLE, cnt=0.
- Reset mid-WAIT: RDY rises immediately and the access is abandoned. No CFG capture; CFG reloads CFG_RESET.
- Access sampled at edge k with N>0:
  - RDY low from edge k to edge k+N.
  - RDY high from edge k+N.
  - Next access sampled at edge k+N+1.
  - Total access length: N+1 PHI2 cycles.
- Access with N=0: one cycle; RDY never drops. Back-to-back zero-wait accesses are sampled on consecutive edges.
- RDY is a registered output (apart from the reset override). The region classifier is purely combinational ahead of the IDLE sample.
- cnt is 2 bits and never wraps. A load of 0 does not enter WAIT.

## Structure

- Package wait_state_pkg:
  - Region enum: RGN_RAM, RGN_ACIA, RGN_VIA, RGN_IO2, RGN_CFG, RGN_EXP, RGN_ROM.
  - Region base-address constants (ADDR[15:10] values).
  - Config field bit positions.
  - State enum: IDLE, WAIT, HOLD.
- Sub-module wait_region_decode: ADDR[15:10] to region enum, combinational, reusable by the chip-select decoder.
- Top module: state register, cnt, CFG register, RDY register.

## Test plan

- Reset, then RAM reads at 0x0400 on 4 consecutive edges -> RDY stays 1; CFG=0x90.
- ROM read at 0xE000 -> RDY 0 for 1 cycle; next access sampled 2 edges later. ACIA read at 0x8000 -> RDY 0 for 2 cycles.
- Write 0x0C to 0x8C00 -> RDY 0 for 1 cycle; CFG=0x0C at the exit edge. Then EXP read at 0x9000 -> 3 wait cycles; ROM read -> 0 waits.
- Read at 0x8C00 with DATA=0xFF -> 1 wait; CFG unchanged.
- With CFG=0xC0, assert RST mid-ACIA wait (cnt=2) -> RDY=1 immediately; CFG=0x90; state IDLE after release.
- Config write setting ACIA to 0 issued directly before an ACIA access -> ACIA access uses 0 waits. An ACIA access already in WAIT keeps its loaded count.
